// File: rtl/uart_baud_pkg.sv
// Shared defaults and helpers for the fractional UART baud/acquisition tick generator.
package uart_baud_pkg;

   localparam int DEF_PERIOD_W   = 13;
   localparam int DEF_FRAC_W     = 8;
   localparam int DEF_OVERSAMPLE = 8;
   localparam int DEF_FRAME_BITS = 10;
   localparam int DEF_FCOMP_W    = 4;

   // Shortest legal acquisition period; smaller programmed values are clamped up to it.
   localparam int MIN_PERIOD     = 2;

   function automatic int idx_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/uart_frac_accum.sv
// Fractional phase accumulator: adds the fraction on each step strobe and registers the carry-out
// so the following acquisition period can be stretched by one clock.
module uart_frac_accum
   import uart_baud_pkg::*;
#(
   parameter int FRAC_W = DEF_FRAC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              step_i,
   input  logic [FRAC_W-1:0] frac_i,
   output logic              carry_o
);

   logic [FRAC_W-1:0] acc_q, acc_d;
   logic              carry_q, carry_d;
   logic [FRAC_W:0]   sum;

   // NOTE: every variable gets a default before any branch, so no path leaves it unassigned (no latch).
   always_comb begin
      sum     = {1'b0, acc_q} + {1'b0, frac_i};
      acc_d   = acc_q;
      carry_d = carry_q;
      if (clear_i) begin
         acc_d   = '0;
         carry_d = 1'b0;
      end else if (step_i) begin
         acc_d   = sum[FRAC_W-1:0];
         carry_d = sum[FRAC_W];
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         carry_q <= carry_d;
      end
   end

   assign carry_o = carry_q;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Baud/acquisition tick generator: fractional acquisition period, per-bit and per-frame ticks,
// frame-end cycle compensation, with configuration shadowed at frame boundaries.
module uart_baud_gen_frac
   import uart_baud_pkg::*;
#(
   parameter int  PERIOD_W   = DEF_PERIOD_W,
   parameter int  FRAC_W     = DEF_FRAC_W,
   parameter int  OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int  FRAME_BITS = DEF_FRAME_BITS,
   parameter int  FCOMP_W    = DEF_FCOMP_W,
   localparam int OS_W       = idx_width(OVERSAMPLE)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                baud_en_i,
   input  logic [PERIOD_W-1:0] acq_period_i,
   input  logic [FRAC_W-1:0]   acq_frac_i,
   input  logic [FCOMP_W-1:0]  frame_comp_i,
   output logic                acq_tick_o,
   output logic                sample_tick_o,
   output logic                baud_tick_o,
   output logic                frame_tick_o,
   output logic [OS_W-1:0]     acq_idx_o,
   output logic [3:0]          bit_idx_o
);

   // Two spare bits cover clamp, carry and frame compensation on top of the integer period.
   localparam int              CNT_W    = PERIOD_W + 2;
   localparam logic [OS_W-1:0] ACQ_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] ACQ_MID  = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);

   logic [PERIOD_W-1:0] per_q, per_d;
   logic [FRAC_W-1:0]   frac_q, frac_d;
   logic [FCOMP_W-1:0]  comp_q, comp_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, period;
   logic [OS_W-1:0]     acq_idx_q, acq_idx_d;
   logic [3:0]          bit_idx_q, bit_idx_d;
   logic                acq_tick_q, acq_tick_d;
   logic                sample_tick_q, sample_tick_d;
   logic                baud_tick_q, baud_tick_d;
   logic                frame_tick_q, frame_tick_d;
   logic                carry, wrap, last_acq;

   uart_frac_accum #(.FRAC_W(FRAC_W)) u_accum (
      .clk     (clk),
      .rst     (rst),
      .clear_i (~baud_en_i),
      .step_i  (wrap),
      .frac_i  (frac_q),
      .carry_o (carry)
   );

   // Current period length: clamped integer part, fractional carry, and the frame-end extension.
   always_comb begin
      last_acq = (acq_idx_q == ACQ_LAST) && (bit_idx_q == BIT_LAST);
      period   = (per_q < PERIOD_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : CNT_W'(per_q);
      period   = period + CNT_W'(carry);
      if (last_acq) period = period + CNT_W'(comp_q);
      wrap     = baud_en_i && (cnt_q == period - CNT_W'(1));
   end

   // Shadow config follows the inputs while idle and is refreshed only at frame boundaries while running.
   always_comb begin
      per_d  = per_q;
      frac_d = frac_q;
      comp_d = comp_q;
      if (!baud_en_i || frame_tick_q) begin
         per_d  = acq_period_i;
         frac_d = acq_frac_i;
         comp_d = frame_comp_i;
      end
   end

   always_comb begin
      cnt_d         = '0;
      acq_idx_d     = '0;
      bit_idx_d     = '0;
      acq_tick_d    = 1'b0;
      sample_tick_d = 1'b0;
      baud_tick_d   = 1'b0;
      frame_tick_d  = 1'b0;
      if (baud_en_i) begin
         cnt_d     = cnt_q + CNT_W'(1);
         acq_idx_d = acq_idx_q;
         bit_idx_d = bit_idx_q;
         if (wrap) begin
            cnt_d         = '0;
            acq_tick_d    = 1'b1;
            sample_tick_d = (acq_idx_q == ACQ_MID);
            if (acq_idx_q == ACQ_LAST) begin
               acq_idx_d   = '0;
               baud_tick_d = 1'b1;
               if (bit_idx_q == BIT_LAST) begin
                  bit_idx_d    = '0;
                  frame_tick_d = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end else begin
               acq_idx_d = acq_idx_q + OS_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         per_q         <= '0;
         frac_q        <= '0;
         comp_q        <= '0;
         cnt_q         <= '0;
         acq_idx_q     <= '0;
         bit_idx_q     <= '0;
         acq_tick_q    <= 1'b0;
         sample_tick_q <= 1'b0;
         baud_tick_q   <= 1'b0;
         frame_tick_q  <= 1'b0;
      end else begin
         per_q         <= per_d;
         frac_q        <= frac_d;
         comp_q        <= comp_d;
         cnt_q         <= cnt_d;
         acq_idx_q     <= acq_idx_d;
         bit_idx_q     <= bit_idx_d;
         acq_tick_q    <= acq_tick_d;
         sample_tick_q <= sample_tick_d;
         baud_tick_q   <= baud_tick_d;
         frame_tick_q  <= frame_tick_d;
      end
   end

   assign acq_tick_o    = acq_tick_q;
   assign sample_tick_o = sample_tick_q;
   assign baud_tick_o   = baud_tick_q;
   assign frame_tick_o  = frame_tick_q;
   assign acq_idx_o     = acq_idx_q;
   assign bit_idx_o     = bit_idx_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Self-checking bench for uart_baud_gen_frac: tick-schedule model checked every cycle,
// plus directed timing checks with hand-computed spacings.
module tb_uart_baud_gen_frac;

   localparam int OS        = 8;
   localparam int FB        = 10;
   localparam int FRAME_LEN = OS * FB;
   localparam int FRAC_ONE  = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        baud_en_i = 1'b0;
   logic [12:0] acq_period_i = '0;
   logic [7:0]  acq_frac_i = '0;
   logic [3:0]  frame_comp_i = '0;
   logic        acq_tick_o, sample_tick_o, baud_tick_o, frame_tick_o;
   logic [2:0]  acq_idx_o;
   logic [3:0]  bit_idx_o;
   logic [10:0] outs;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   uart_baud_gen_frac dut (
      .clk           (clk),
      .rst           (rst),
      .baud_en_i     (baud_en_i),
      .acq_period_i  (acq_period_i),
      .acq_frac_i    (acq_frac_i),
      .frame_comp_i  (frame_comp_i),
      .acq_tick_o    (acq_tick_o),
      .sample_tick_o (sample_tick_o),
      .baud_tick_o   (baud_tick_o),
      .frame_tick_o  (frame_tick_o),
      .acq_idx_o     (acq_idx_o),
      .bit_idx_o     (bit_idx_o)
   );

   always #5 clk = ~clk;

   assign outs = {acq_tick_o, sample_tick_o, baud_tick_o, frame_tick_o, acq_idx_o, bit_idx_o};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int now_cyc();
      return int'(($time - 5) / 10);
   endfunction

   // ---------------- behavioural model: schedule of tick times ----------------
   int mcyc = 0;
   bit m_run = 1'b0;
   int m_n = 0;
   int m_next = 0;
   int m_acc = 0;
   bit m_carry = 1'b0;
   int m_N = 0, m_F = 0, m_C = 0;

   function automatic int plen(input int n);
      int base;
      base = (m_N < 2) ? 2 : m_N;
      return base + int'(m_carry) + ((n % FRAME_LEN == FRAME_LEN - 1) ? m_C : 0);
   endfunction

   always @(negedge clk) begin
      bit tk;
      logic [10:0] e_vec;
      tk = m_run && (mcyc == m_next);
      if (tk) m_n = m_n + 1;
      e_vec = {tk, tk && (m_n % OS == OS / 2), tk && (m_n % OS == 0), tk && (m_n % FRAME_LEN == 0),
               3'(m_run ? m_n % OS : 0), 4'(m_run ? (m_n / OS) % FB : 0)};
      if (chk_on) check($sformatf("model@%0d", mcyc), 32'(outs), 32'(e_vec));
      if (rst) begin
         m_run = 1'b0; m_acc = 0; m_carry = 1'b0;
         m_N = 0; m_F = 0; m_C = 0;
      end else if (!baud_en_i) begin
         m_run = 1'b0; m_acc = 0; m_carry = 1'b0;
         m_N = int'(acq_period_i); m_F = int'(acq_frac_i); m_C = int'(frame_comp_i);
      end else if (!m_run) begin
         m_run  = 1'b1;
         m_n    = 0;
         m_next = mcyc + plen(0);
      end else if (tk) begin
         m_carry = (m_acc + m_F) >= FRAC_ONE;
         m_acc   = (m_acc + m_F) % FRAC_ONE;
         if (m_n % FRAME_LEN == 0) begin
            m_N = int'(acq_period_i); m_F = int'(acq_frac_i); m_C = int'(frame_comp_i);
         end
         m_next = mcyc + plen(m_n);
      end
      mcyc = mcyc + 1;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int n, input int f, input int c);
      acq_period_i = 13'(n);
      acq_frac_i   = 8'(f);
      frame_comp_i = 4'(c);
   endtask

   // which: 0 acq, 1 sample, 2 baud, 3 frame; returns the cycle the tick was seen in
   task automatic wait_tick(input int which, input int budget, output int t);
      logic s;
      t = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         case (which)
            0:       s = acq_tick_o;
            1:       s = sample_tick_o;
            2:       s = baud_tick_o;
            default: s = frame_tick_o;
         endcase
         if (s === 1'b1) begin
            t = now_cyc();
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL wait_tick%0d: no tick within %0d cycles", which, budget);
   endtask

   task automatic restart(input int n, input int f, input int c, output int t0);
      step(1);
      baud_en_i = 1'b0;
      set_cfg(n, f, c);
      step(3);
      baud_en_i = 1'b1;
      t0 = now_cyc();
   endtask

   initial begin
      int t0, t1, t2, t3, t4, t5, prev;
      bit found;

      set_cfg(0, 0, 0);
      step(3);
      chk_on = 1'b1;
      check("reset_outs", 32'(outs), 32'd0);
      rst = 1'b0;
      step(2);
      check("idle_outs", 32'(outs), 32'd0);

      // N=54, F=64: periods 54,54,54,54,55,... and 434 clk per bit in steady state
      restart(54, 64, 0, t0);
      wait_tick(0, 200, t1);
      check("t1_first_acq", 32'(t1 - t0), 32'd54);
      wait_tick(0, 200, t2);
      wait_tick(0, 200, t3);
      wait_tick(0, 200, t4);
      wait_tick(0, 200, t5);
      check("t1_gap34", 32'(t4 - t3), 32'd54);
      check("t1_gap45", 32'(t5 - t4), 32'd55);
      wait_tick(2, 1000, t1);
      check("t1_first_baud", 32'(t1 - t0), 32'd433);
      wait_tick(2, 1000, t2);
      wait_tick(2, 1000, t3);
      check("t1_baud_gap_a", 32'(t2 - t1), 32'd434);
      check("t1_baud_gap_b", 32'(t3 - t2), 32'd434);

      // N=54, F=0, comp=3: frame 4323 clk, last bit 435 clk
      restart(54, 0, 3, t0);
      wait_tick(3, 6000, t1);
      check("t2_first_frame", 32'(t1 - t0), 32'd4323);
      prev = t1;
      for (int i = 1; i <= FB; i++) begin
         wait_tick(2, 1000, t2);
         if (i == 1)  check("t2_bit_gap", 32'(t2 - prev), 32'd432);
         if (i == FB) begin
            check("t2_last_bit_gap", 32'(t2 - prev), 32'd435);
            check("t2_frame_with_baud", 32'(frame_tick_o), 32'd1);
         end
         prev = t2;
      end
      check("t2_frame_gap", 32'(prev - t1), 32'd4323);

      // N=10: first acq at +10, sample on 4th tick, baud on 8th
      restart(10, 0, 0, t0);
      wait_tick(0, 100, t1);
      check("t3_first_acq", 32'(t1 - t0), 32'd10);
      wait_tick(1, 100, t2);
      check("t3_sample", 32'(t2 - t0), 32'd40);
      wait_tick(2, 200, t3);
      check("t3_baud", 32'(t3 - t0), 32'd80);

      // disable at acq_idx=5, bit_idx=3
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge clk);
         if (acq_idx_o == 3'd5 && bit_idx_o == 4'd3) found = 1'b1;
      end
      check("t4_reach_idx", 32'(found), 32'd1);
      step(1);
      baud_en_i = 1'b0;
      step(1);
      check("t4_disabled_outs", 32'(outs), 32'd0);
      step(2);
      baud_en_i = 1'b1;
      t0 = now_cyc();
      wait_tick(0, 100, t1);
      check("t4_reenable_acq", 32'(t1 - t0), 32'd10);

      // N 54 -> 20 mid-frame: effective only after frame_tick
      restart(54, 0, 0, t0);
      for (int i = 0; i < 3; i++) wait_tick(2, 1000, t1);
      step(1);
      set_cfg(20, 0, 0);
      wait_tick(0, 200, t1);
      wait_tick(0, 200, t2);
      check("t5_old_period", 32'(t2 - t1), 32'd54);
      wait_tick(3, 6000, t3);
      wait_tick(0, 200, t4);
      check("t5_new_period", 32'(t4 - t3), 32'd20);

      // N=0 and N=1 clamp to 2; rst mid-frame
      restart(0, 0, 0, t0);
      wait_tick(0, 20, t1);
      wait_tick(0, 20, t2);
      check("t6_n0_gap", 32'(t2 - t1), 32'd2);
      restart(1, 0, 0, t0);
      wait_tick(0, 20, t1);
      wait_tick(0, 20, t2);
      check("t6_n1_gap", 32'(t2 - t1), 32'd2);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (bit_idx_o == 4'd2 && acq_idx_o == 3'd3) found = 1'b1;
      end
      check("t6_reach_idx", 32'(found), 32'd1);
      step(1);
      rst = 1'b1;
      step(1);
      check("t6_rst_outs", 32'(outs), 32'd0);
      step(2);
      rst = 1'b0;
      step(20);

      // randomized segments: config churn, short disables, occasional reset
      for (int r = 0; r < 10; r++) begin
         int run;
         restart($urandom_range(0, 12), $urandom_range(0, 255), $urandom_range(0, 7), t0);
         run = $urandom_range(300, 2000);
         for (int k = 0; k < run; k++) begin
            step(1);
            if ($urandom_range(0, 199) == 0)
               set_cfg($urandom_range(0, 12), $urandom_range(0, 255), $urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) begin
               baud_en_i = 1'b0;
               step($urandom_range(1, 4));
               baud_en_i = 1'b1;
            end
            if (r == 5 && k == run / 2) begin
               rst = 1'b1;
               step(2);
               rst = 1'b0;
            end
         end
      end

      step(1);
      baud_en_i = 1'b0;
      step(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
